// File: rtl/game_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : game_ctrl
// Desc     : Game-flow sequencer: title, play, crash and game-over states,
//            lives, saturating score, post-crash invulnerability and blink.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctrl #(
   parameter int N_AST         = 5,
   parameter int LIVES_INIT    = 3,
   parameter int CRASH_FRAMES  = 60,
   parameter int INVULN_FRAMES = 120,
   parameter int SCORE_MAX     = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pixpulse,
   input  logic             vblank,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic [N_AST-1:0] collision,
   input  logic [N_AST-1:0] score_inc,
   output logic [1:0]       state,
   output logic             move,
   output logic             obj_rst,
   output logic [8:0]       score,
   output logic [1:0]       lives,
   output logic             invuln,
   output logic             ship_blink
);

   typedef enum logic [1:0] {
      ST_TITLE     = 2'd0,
      ST_PLAY      = 2'd1,
      ST_GAME_OVER = 2'd2,
      ST_CRASH     = 2'd3
   } state_t;

   localparam logic [1:0] c_lives_init  = 2'(LIVES_INIT);
   localparam logic [7:0] c_crash_last  = 8'(CRASH_FRAMES - 1);
   localparam logic [7:0] c_invuln_last = 8'(INVULN_FRAMES - 1);
   localparam logic [9:0] c_score_max   = 10'(SCORE_MAX);

   state_t     r_state;
   logic [8:0] r_score;
   logic [1:0] r_lives;
   logic       r_invuln;
   logic [7:0] r_counter;
   logic       r_vblank_d1;
   logic       r_armed;

   logic       w_frame_tick;
   logic       w_any_btn;
   logic       w_all_btn;
   logic       w_hit;
   logic [8:0] w_pop;
   logic [9:0] w_sum;
   logic       w_sat;
   logic [8:0] w_score_next;

   // r_armed blocks a spurious tick when vblank is already high at reset release
   assign w_frame_tick = pixpulse & vblank & ~r_vblank_d1 & r_armed;
   assign w_any_btn    = btn_up | btn_down | btn_left | btn_right;
   assign w_all_btn    = btn_up & btn_down & btn_left & btn_right;
   assign w_hit        = (|collision) & ~r_invuln;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < N_AST; i++) begin
         w_pop = w_pop + {8'd0, score_inc[i]};
      end
   end

   assign w_sum        = {1'b0, r_score} + {1'b0, w_pop};
   assign w_sat        = (w_sum >= c_score_max);
   assign w_score_next = w_sat ? c_score_max[8:0] : w_sum[8:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_TITLE;
         r_score     <= '0;
         r_lives     <= c_lives_init;
         r_invuln    <= 1'b0;
         r_counter   <= '0;
         r_vblank_d1 <= 1'b0;
         r_armed     <= 1'b0;
      end else if (pixpulse) begin
         r_vblank_d1 <= vblank;
         if (!vblank) begin
            r_armed <= 1'b1;
         end
         case (r_state)
            ST_TITLE: begin
               if (w_frame_tick && w_any_btn) begin
                  r_state   <= ST_PLAY;
                  r_lives   <= c_lives_init;
                  r_score   <= '0;
                  r_invuln  <= 1'b0;
                  r_counter <= '0;
               end
            end
            ST_PLAY: begin
               if (w_hit) begin
                  // score_inc of this pixpulse is dropped when a hit lands
                  if (r_lives > 2'd1) begin
                     r_lives   <= r_lives - 2'd1;
                     r_counter <= '0;
                     r_state   <= ST_CRASH;
                  end else begin
                     r_lives <= 2'd0;
                     r_state <= ST_GAME_OVER;
                  end
               end else begin
                  r_score <= w_score_next;
                  if (w_sat) begin
                     r_state <= ST_GAME_OVER;
                  end
                  if (r_invuln && w_frame_tick) begin
                     if (r_counter == c_invuln_last) begin
                        r_invuln  <= 1'b0;
                        r_counter <= '0;
                     end else begin
                        r_counter <= r_counter + 8'd1;
                     end
                  end
               end
            end
            ST_CRASH: begin
               if (w_frame_tick) begin
                  if (r_counter == c_crash_last) begin
                     r_state   <= ST_PLAY;
                     r_invuln  <= 1'b1;
                     r_counter <= '0;
                  end else begin
                     r_counter <= r_counter + 8'd1;
                  end
               end
            end
            ST_GAME_OVER: begin
               if (w_frame_tick && w_all_btn) begin
                  r_state   <= ST_TITLE;
                  r_score   <= '0;
                  r_lives   <= c_lives_init;
                  r_invuln  <= 1'b0;
                  r_counter <= '0;
               end
            end
            default: r_state <= ST_TITLE;
         endcase
      end
   end

   assign state      = r_state;
   assign score      = r_score;
   assign lives      = r_lives;
   assign invuln     = r_invuln;
   assign move       = w_frame_tick & (r_state == ST_PLAY);
   assign obj_rst    = (r_state != ST_PLAY);
   assign ship_blink = r_invuln & r_counter[3];

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_game_ctrl
// Desc     : Directed bench for game_ctrl: start, crash, invulnerability,
//            game over by lives and by score, reset during crash.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       pixpulse;
   logic       vblank;
   logic       btn_up, btn_down, btn_left, btn_right;
   logic [4:0] collision;
   logic [4:0] score_inc;
   logic [1:0] state;
   logic       move;
   logic       obj_rst;
   logic [8:0] score;
   logic [1:0] lives;
   logic       invuln;
   logic       ship_blink;

   int n_err    = 0;
   int n_checks = 0;
   int n_move   = 0;
   int k, m, bl_err;

   game_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .pixpulse   (pixpulse),
      .vblank     (vblank),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .collision  (collision),
      .score_inc  (score_inc),
      .state      (state),
      .move       (move),
      .obj_rst    (obj_rst),
      .score      (score),
      .lives      (lives),
      .invuln     (invuln),
      .ship_blink (ship_blink)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One pixpulse every four clocks; move is sampled while pixpulse is high
   task automatic pix(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pixpulse = 1'b1;
         #1;
         if (move === 1'b1) n_move++;
         @(negedge clk);
         pixpulse = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   // One frame: vblank high for 2 pixpulses, low for 6 -> one frame tick
   task automatic frame();
      vblank = 1'b1;
      pix(2);
      vblank = 1'b0;
      pix(6);
   endtask

   task automatic run_crash(output int cnt);
      cnt = 0;
      while (state == 2'd3 && cnt < 100) begin
         frame();
         cnt++;
      end
   endtask

   task automatic run_invuln(input bit hold_coll, output int cnt, output int errs);
      cnt  = 0;
      errs = 0;
      if (hold_coll) collision = 5'b11111;
      while (invuln === 1'b1 && cnt < 200) begin
         if (ship_blink !== cnt[3]) errs++;
         if (lives !== 2'd2 && hold_coll) errs++;
         frame();
         cnt++;
         if (cnt == 100) collision = 5'b00000;
      end
      collision = 5'b00000;
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; pixpulse = 1'b0; vblank = 1'b1;
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b1; btn_right = 1'b0;
      collision = '0; score_inc = '0;
      repeat (3) @(negedge clk);
      chk("rst_state",  16'(state),      16'd0);
      chk("rst_score",  16'(score),      16'd0);
      chk("rst_lives",  16'(lives),      16'd3);
      chk("rst_invuln", 16'(invuln),     16'd0);
      chk("rst_objrst", 16'(obj_rst),    16'd1);
      chk("rst_blink",  16'(ship_blink), 16'd0);
      rst = 1'b1;

      // vblank already high at release: no tick until a real 0->1 edge
      pix(3);
      chk("no_tick_after_rst", 16'(state), 16'd0);
      btn_left = 1'b0;
      vblank = 1'b0;
      pix(6);
      n_move = 0;
      frame(); frame();
      chk("title_idle_state", 16'(state),  16'd0);
      chk("title_no_move",    16'(n_move), 16'd0);

      btn_left = 1'b1;
      frame();
      btn_left = 1'b0;
      chk("start_state",  16'(state),   16'd1);
      chk("start_lives",  16'(lives),   16'd3);
      chk("start_score",  16'(score),   16'd0);
      chk("start_objrst", 16'(obj_rst), 16'd0);
      n_move = 0;
      frame(); frame(); frame();
      chk("move_per_frame", 16'(n_move), 16'd3);

      // First hit -> CRASH for 60 frames, then 120 invulnerable frames
      collision = 5'b00100;
      pix(1);
      collision = 5'b00000;
      chk("hit1_lives",  16'(lives),   16'd2);
      chk("hit1_state",  16'(state),   16'd3);
      chk("hit1_objrst", 16'(obj_rst), 16'd1);
      n_move = 0;
      run_crash(k);
      chk("crash1_frames",  16'(k),      16'd60);
      chk("crash_no_move",  16'(n_move), 16'd0);
      chk("post_crash_state",  16'(state),  16'd1);
      chk("post_crash_invuln", 16'(invuln), 16'd1);
      run_invuln(1'b1, m, bl_err);
      chk("invuln1_frames", 16'(m),      16'd120);
      chk("invuln1_blink",  16'(bl_err), 16'd0);
      chk("invuln1_lives",  16'(lives),  16'd2);
      chk("invuln1_state",  16'(state),  16'd1);
      chk("invuln1_blink_off", 16'(ship_blink), 16'd0);

      // Second and third hits -> GAME_OVER with no lives left
      collision = 5'b00001;
      pix(1);
      collision = 5'b00000;
      chk("hit2_lives", 16'(lives), 16'd1);
      run_crash(k);
      chk("crash2_frames", 16'(k), 16'd60);
      run_invuln(1'b0, m, bl_err);
      chk("invuln2_frames", 16'(m), 16'd120);
      collision = 5'b10000;
      pix(1);
      collision = 5'b00000;
      chk("hit3_state", 16'(state), 16'd2);
      chk("hit3_lives", 16'(lives), 16'd0);

      // GAME_OVER ignores play inputs and needs all four buttons
      collision = 5'b11111; score_inc = 5'b11111;
      pix(3);
      collision = 5'b00000; score_inc = 5'b00000;
      chk("go_hold_score", 16'(score), 16'd0);
      chk("go_hold_lives", 16'(lives), 16'd0);
      btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1;
      frame();
      chk("go_three_btn", 16'(state), 16'd2);
      btn_right = 1'b1;
      frame();
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      chk("go_to_title", 16'(state), 16'd0);
      chk("title_lives", 16'(lives), 16'd3);

      // Score saturation: 253 + 3 -> 255 and GAME_OVER
      btn_right = 1'b1;
      frame();
      btn_right = 1'b0;
      score_inc = 5'b11111;
      pix(50);
      chk("score_250", 16'(score), 16'd250);
      score_inc = 5'b00111;
      pix(1);
      chk("score_253", 16'(score), 16'd253);
      score_inc = 5'b10101;
      pix(1);
      score_inc = 5'b00000;
      chk("sat_score", 16'(score), 16'd255);
      chk("sat_state", 16'(state), 16'd2);
      btn_up = 1'b1; btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
      frame();
      btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      chk("title2_state", 16'(state), 16'd0);
      chk("title2_score", 16'(score), 16'd0);
      chk("title2_lives", 16'(lives), 16'd3);

      // Hit and saturation together: hit wins, score_inc discarded
      btn_up = 1'b1;
      frame();
      btn_up = 1'b0;
      score_inc = 5'b11111;
      pix(50);
      score_inc = 5'b00111;
      pix(1);
      collision = 5'b00001; score_inc = 5'b10101;
      pix(1);
      collision = 5'b00000; score_inc = 5'b00000;
      chk("hitsat_state", 16'(state), 16'd3);
      chk("hitsat_score", 16'(score), 16'd253);
      chk("hitsat_lives", 16'(lives), 16'd2);

      // Asynchronous reset mid-CRASH, between pixpulses
      repeat (30) frame();
      chk("mid_crash_state", 16'(state), 16'd3);
      rst = 1'b0;
      #1;
      chk("arst_state",  16'(state),   16'd0);
      chk("arst_invuln", 16'(invuln),  16'd0);
      chk("arst_score",  16'(score),   16'd0);
      chk("arst_lives",  16'(lives),   16'd3);
      chk("arst_objrst", 16'(obj_rst), 16'd1);
      @(negedge clk);
      rst = 1'b1;
      pix(2);
      btn_down = 1'b1;
      frame();
      btn_down = 1'b0;
      chk("restart_state",  16'(state),  16'd1);
      chk("restart_invuln", 16'(invuln), 16'd0);
      collision = 5'b01000;
      pix(1);
      collision = 5'b00000;
      run_crash(k);
      chk("crash_after_rst_frames", 16'(k), 16'd60);
      chk("crash_after_rst_invuln", 16'(invuln), 16'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
